// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared states, error codes and command constants for uart_cmd_ctrl
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_ADDR    = 3'd2,
        ST_LEN     = 3'd3,
        ST_PAYLOAD = 3'd4,
        ST_CHK     = 3'd5,
        ST_COMMIT  = 3'd6
    } state_t;

    localparam logic [1:0] ERR_BAD_CMD = 2'd0;
    localparam logic [1:0] ERR_BAD_LEN = 2'd1;
    localparam logic [1:0] ERR_BAD_CHK = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] CMD_WRITE = 8'h01;

endpackage

// File: rtl/uart_cmd_buf.sv
// rtl/uart_cmd_buf.sv - payload buffer, DEPTH x 8, one write port and one asynchronous read port
module uart_cmd_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - UART command frame parser and register-write engine; define UART_CMD_CHK_EN for the trailing checksum byte
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 200_000,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic       wr_ready,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy,
    output logic       overrun
);

    localparam int            AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    LEN_MAX   = 8'(MAX_LEN);

    state_t        state_q, state_n;
    logic [7:0]    addr_q, addr_n;
    logic [7:0]    len_q, len_n;
    logic [7:0]    idx_q, idx_n;
    logic [TW-1:0] tcnt_q, tcnt_n;
    logic          wr_en_n, frame_ok_n, frame_err_n, overrun_n;
    logic [7:0]    wr_addr_n, wr_data_n;
    logic [1:0]    err_code_n;
    logic          go_commit, timed, expired;
    logic          buf_we;
    logic [AW-1:0] buf_waddr, buf_raddr;
    logic [7:0]    buf_rdata, first_data;

    uart_cmd_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (buf_waddr),
        .wdata (rx_data),
        .raddr (buf_raddr),
        .rdata (buf_rdata)
    );

    assign busy      = (state_q != ST_IDLE);
    assign buf_waddr = AW'(idx_q);
    assign buf_raddr = (state_q == ST_COMMIT) ? AW'(idx_q + 8'd1) : '0;
    // A one-byte frame can enter COMMIT in the same cycle its only byte is written
    assign first_data = (buf_we && (buf_waddr == buf_raddr)) ? rx_data : buf_rdata;
    assign timed      = (state_q != ST_IDLE) && (state_q != ST_COMMIT);
    assign expired    = timed && !rx_valid && (tcnt_q == TCNT_LAST);

`ifdef UART_CMD_CHK_EN
    logic [7:0] sum_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else if (rx_valid) begin
            if (state_q == ST_CMD) begin
                sum_q <= rx_data;
            end else if (state_q inside {ST_ADDR, ST_LEN, ST_PAYLOAD}) begin
                sum_q <= sum_q + rx_data;
            end
        end
    end
`endif

    always_comb begin
        state_n     = state_q;
        addr_n      = addr_q;
        len_n       = len_q;
        idx_n       = idx_q;
        tcnt_n      = '0;
        wr_en_n     = wr_en;
        wr_addr_n   = wr_addr;
        wr_data_n   = wr_data;
        frame_ok_n  = 1'b0;
        frame_err_n = 1'b0;
        err_code_n  = err_code;
        overrun_n   = overrun;
        buf_we      = 1'b0;
        go_commit   = 1'b0;

        if (timed && !rx_valid) begin
            tcnt_n = tcnt_q + TW'(1);
        end

        if (expired) begin
            state_n     = ST_IDLE;
            frame_err_n = 1'b1;
            err_code_n  = ERR_TIMEOUT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_valid && (rx_data == SYNC_BYTE)) begin
                        state_n = ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (rx_valid) begin
                        if (rx_data == CMD_WRITE) begin
                            state_n = ST_ADDR;
                        end else begin
                            state_n     = ST_IDLE;
                            frame_err_n = 1'b1;
                            err_code_n  = ERR_BAD_CMD;
                        end
                    end
                end
                ST_ADDR: begin
                    if (rx_valid) begin
                        addr_n  = rx_data;
                        state_n = ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (rx_valid) begin
                        if ((rx_data == 8'd0) || (rx_data > LEN_MAX)) begin
                            state_n     = ST_IDLE;
                            frame_err_n = 1'b1;
                            err_code_n  = ERR_BAD_LEN;
                        end else begin
                            len_n   = rx_data;
                            idx_n   = '0;
                            state_n = ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (rx_valid) begin
                        buf_we = 1'b1;
                        if (idx_q == len_q - 8'd1) begin
`ifdef UART_CMD_CHK_EN
                            state_n = ST_CHK;
`else
                            go_commit = 1'b1;
`endif
                        end else begin
                            idx_n = idx_q + 8'd1;
                        end
                    end
                end
`ifdef UART_CMD_CHK_EN
                ST_CHK: begin
                    if (rx_valid) begin
                        if (rx_data == sum_q) begin
                            go_commit = 1'b1;
                        end else begin
                            state_n     = ST_IDLE;
                            frame_err_n = 1'b1;
                            err_code_n  = ERR_BAD_CHK;
                        end
                    end
                end
`endif
                ST_COMMIT: begin
                    if (rx_valid) begin
                        overrun_n = 1'b1;
                    end
                    if (wr_en && wr_ready) begin
                        if (idx_q == len_q - 8'd1) begin
                            wr_en_n    = 1'b0;
                            frame_ok_n = 1'b1;
                            state_n    = ST_IDLE;
                        end else begin
                            idx_n     = idx_q + 8'd1;
                            wr_addr_n = wr_addr + 8'd1;
                            wr_data_n = buf_rdata;
                        end
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end

        if (go_commit) begin
            state_n   = ST_COMMIT;
            idx_n     = '0;
            wr_en_n   = 1'b1;
            wr_addr_n = addr_q;
            wr_data_n = first_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            tcnt_q    <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= '0;
            overrun   <= 1'b0;
        end else begin
            state_q   <= state_n;
            addr_q    <= addr_n;
            len_q     <= len_n;
            idx_q     <= idx_n;
            tcnt_q    <= tcnt_n;
            wr_en     <= wr_en_n;
            wr_addr   <= wr_addr_n;
            wr_data   <= wr_data_n;
            frame_ok  <= frame_ok_n;
            frame_err <= frame_err_n;
            err_code  <= err_code_n;
            overrun   <= overrun_n;
        end
    end

endmodule
